io_write_arbiter: RTL

IO_WRITE_ARBITER -- requirements
Module: io_write_arbiter

---
 rtl/io_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 26 ++
 rtl/io_write_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// ============================================================================
// io_pkg : shared types and constants for the IO write arbiter.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } io_state_e;

    localparam int   DATA_W_DEF = 64;
    localparam logic REQ_CPU    = 1'b0;
    localparam logic REQ_GAME   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// rr_arb2 : two-requester round-robin selector (pure combinational).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        // On a tie the requester that did not win last time gets the channel.
        if (&req) begin
            gnt_id = ~last;
        end else begin
            gnt_id = req[1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/io_write_arbiter.sv
// ============================================================================
// io_write_arbiter : two-port round-robin write arbiter in front of an IO bus.
// Optional WAIT timeout enabled by defining IO_ARB_TIMEOUT_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module io_write_arbiter
    import io_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    output logic [1:0]        req_ready,
    output logic [1:0]        req_done,
    output logic              io_we,
    output logic [DATA_W-1:0] io_wdata,
    input  logic              io_waitrequest,
    output logic              busy,
    output logic              grant_id,
    output logic              err
);

    generate
        if (TIMEOUT_CYC < 1) begin : g_bad_timeout
            $error("io_write_arbiter: TIMEOUT_CYC must be at least 1");
        end
    endgenerate

    io_state_e         state_q, state_d;
    logic [DATA_W-1:0] io_wdata_q, io_wdata_d;
    logic              grant_id_q, grant_id_d;
    logic              last_grant_q, last_grant_d;
    logic              io_we_q, io_we_d;
    logic [1:0]        req_done_q, req_done_d;
    logic              gnt_valid;
    logic              gnt_id;
    logic              accept;
    logic              timeout;

    rr_arb2 u_rr_arb2 (
        .req       (req_valid),
        .last      (last_grant_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    assign accept = (state_q == IDLE) && gnt_valid;

    // Ready is combinational from req_valid, so it must be masked while reset is held.
    assign req_ready[REQ_CPU]  = rst_n && accept && (gnt_id == REQ_CPU);
    assign req_ready[REQ_GAME] = rst_n && accept && (gnt_id == REQ_GAME);

`ifdef IO_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;

    assign timeout = (state_q == WAIT) && io_waitrequest
                     && (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        err_d      = timeout;
        if (state_q == ISSUE) begin
            wait_cnt_d = '0;
        end else if ((state_q == WAIT) && io_waitrequest && !timeout) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        io_wdata_d   = io_wdata_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        io_we_d      = 1'b0;
        req_done_d   = 2'b00;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = ISSUE;
                    io_wdata_d   = (gnt_id == REQ_GAME) ? req_data1 : req_data0;
                    grant_id_d   = gnt_id;
                    last_grant_d = gnt_id;
                    io_we_d      = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!io_waitrequest) begin
                    state_d                = DONE;
                    req_done_d[grant_id_q] = 1'b1;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            io_wdata_q   <= '0;
            grant_id_q   <= REQ_CPU;
            last_grant_q <= REQ_GAME;
            io_we_q      <= 1'b0;
            req_done_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            io_wdata_q   <= io_wdata_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            io_we_q      <= io_we_d;
            req_done_q   <= req_done_d;
        end
    end

    assign io_we    = io_we_q;
    assign io_wdata = io_wdata_q;
    assign grant_id = grant_id_q;
    assign req_done = req_done_q;
    assign busy     = (state_q != IDLE);

endmodule

`default_nettype wire
